// File: rtl/xcvr_bus_seq.sv
// Bus-cycle sequencer for one 8-bit transceiver channel, A side.
// Turns single-byte host requests into DIR/_CS/_STB cycles and drives or samples the A bus.
module xcvr_bus_seq #(
  parameter int unsigned T_TURN   = 2,
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 4,
  parameter int unsigned T_HOLD   = 1,
  parameter int unsigned CW       = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       wr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       dir_o,
  output logic       cs_no,
  output logic       stb_no,
  inout  wire  [7:0] d_io
);

  localparam logic [CW-1:0] TurnLd   = CW'(T_TURN - 1);
  localparam logic [CW-1:0] SetupLd  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] StrobeLd = CW'(T_STROBE - 1);
  localparam logic [CW-1:0] HoldLd   = CW'(T_HOLD - 1);

  typedef enum logic [2:0] {StIdle, StTurn, StSetup, StStrobe, StHold} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          wr_q, wr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          cs_n_q, cs_n_d;
  logic          stb_n_q, stb_n_d;
  logic          oe_q, oe_d;
  logic          active_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          wr_d    = wr_i;
          wdata_d = wdata_i;
          if (wr_i != dir_q) begin
            // DIR only moves here, while _CS is still high
            dir_d   = wr_i;
            state_d = StTurn;
            cnt_d   = TurnLd;
          end else begin
            state_d = StSetup;
            cnt_d   = SetupLd;
          end
        end
      end
      StTurn: begin
        if (cnt_q == '0) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          if (!wr_q) rdata_d = d_io;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops
    active_d = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
    cs_n_d   = !active_d;
    stb_n_d  = (state_d != StStrobe);
    busy_d   = (state_d != StIdle);
    oe_d     = wr_d && active_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      stb_n_q <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      stb_n_q <= stb_n_d;
      oe_q    <= oe_d;
    end
  end

  assign d_io    = oe_q ? wdata_q : 8'hzz;
  assign rdata_o = rdata_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign dir_o   = dir_q;
  assign cs_no   = cs_n_q;
  assign stb_no  = stb_n_q;

endmodule
